// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: fetch queue entry, XLEN and the canonical NOP.
// The misaligned field exists only when FETCH_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef FETCH_MISALIGN_TRAP_EN
        logic            misaligned;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry register queue of fetch entries; slot 0 is always the head.
// Flush wins over push/pop; push and pop together when full keeps the count at 2.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot0_q, slot0_d;
    fetch_entry_t slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push && pop && count_q != 2'd0) begin
            if (count_q == 2'd1) begin
                slot0_d = wr_entry;
            end else begin
                slot0_d = slot1_q;
                slot1_d = wr_entry;
            end
        end else if (push && count_q != 2'd2) begin
            if (count_q == 2'd0) begin
                slot0_d = wr_entry;
            end else begin
                slot1_d = wr_entry;
            end
            count_d = count_q + 2'd1;
        end else if (pop && count_q != 2'd0) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = slot0_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, Instruction_Memory read port, 2-entry queue.
// FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect trap entry and sticky halt.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            if_misaligned,
`endif
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    // Decode handshake: the head transfers on a clock edge where if_valid && if_ready
    // and no redirect is present; a head shown during a redirect cycle is killed.
    logic [XLEN-1:0] pc_q, pc_d;
    logic            push, pop, flush;
    logic [1:0]      count;
    fetch_entry_t    wr_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt_q, halt_d;
    logic trap_pend_q, trap_pend_d;
`endif

    always_comb begin
        pc_d     = pc_q;
        flush    = redirect_valid;
        pop      = if_valid && if_ready && !redirect_valid;
        wr_entry.pc = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        halt_d      = halt_q;
        trap_pend_d = trap_pend_q;
        push = !redirect_valid && (!halt_q || trap_pend_q) && (int'(count) < DEPTH || pop);
        wr_entry.instr      = trap_pend_q ? NOP : imem_instr;
        wr_entry.misaligned = trap_pend_q;
        if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                // Keep the unmasked target so the trap entry reports it exactly.
                pc_d        = redirect_pc;
                halt_d      = 1'b1;
                trap_pend_d = 1'b1;
            end else begin
                pc_d        = redirect_pc;
                halt_d      = 1'b0;
                trap_pend_d = 1'b0;
            end
        end else if (push) begin
            if (trap_pend_q) begin
                trap_pend_d = 1'b0;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
`else
        push = !redirect_valid && (int'(count) < DEPTH || pop);
        wr_entry.instr = imem_instr;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_q      <= 1'b0;
            trap_pend_q <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_q      <= halt_d;
            trap_pend_q <= trap_pend_d;
`endif
        end
    end

    fetch_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .count    (count),
        .head     (head)
    );

    assign imem_addr = pc_q;
    assign if_valid  = (count != 2'd0);
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign if_misaligned = head.misaligned;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand sequences for
// redirect masking/trap (FETCH_MISALIGN_TRAP_EN), PC wrap and asynchronous reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_instr, redirect_pc, if_instr, if_pc;
    logic        redirect_valid, if_valid, if_ready;
    logic [31:0] w_addr, w_imem, w_instr, w_pc;
    logic        w_valid;
    logic        mis0, w_mis;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);
    assign w_imem     = mem_word(w_addr);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misaligned  (mis0),
`endif
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misaligned  (w_mis),
`endif
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (w_addr),
        .imem_instr     (w_imem),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (w_valid),
        .if_ready       (1'b1),
        .if_instr       (w_instr),
        .if_pc          (w_pc)
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign mis0  = 1'b0;
    assign w_mis = 1'b0;
`endif

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic        chk_head;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Released with ready=0: fill to 2, stall, drain, redirect, refill.
        vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h11, 32'h4};
        vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h11, 32'h8};
        vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h11, 32'h8};
        vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h11, 32'h8};
        vt[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h11, 32'h8};
        vt[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,  32'h22, 32'hC};
        vt[6]  = '{1'b1, 1'b1, 32'h10,  1'b0, 1'b0, 32'h0,  32'h0,  32'h10};
        vt[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10, mem_word(32'h10), 32'h14};
        vt[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14, mem_word(32'h14), 32'h18};
        vt[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18, mem_word(32'h18), 32'h1C};
        vt[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18, mem_word(32'h18), 32'h20};
        vt[11] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,  32'h100};
        vt[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, mem_word(32'h100), 32'h104};

        rst_n = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, if_valid}, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_if_pc", if_pc, 32'h0);
        chk("reset_if_instr", if_instr, 32'h0);
        chk("reset_mis", {31'b0, mis0}, 32'h0);
        chk("reset_w_addr", w_addr, 32'hFFFF_FFFC);
        chk("reset_w_valid", {31'b0, w_valid}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if_ready       = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            step();
            chk($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vt[i].ev});
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].eaddr);
            if (vt[i].chk_head) begin
                chk($sformatf("vec%0d_pc", i), if_pc, vt[i].epc);
                chk($sformatf("vec%0d_instr", i), if_instr, vt[i].einstr);
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        step();
        chk("trap_redir_valid", {31'b0, if_valid}, 32'h0);
        chk("trap_redir_addr", imem_addr, 32'h6);
        @(negedge clk);
        redirect_valid = 1'b0;
        step();
        chk("trap_entry_valid", {31'b0, if_valid}, 32'h1);
        chk("trap_entry_pc", if_pc, 32'h6);
        chk("trap_entry_instr", if_instr, 32'h0000_0013);
        chk("trap_entry_mis", {31'b0, mis0}, 32'h1);
        step();
        chk("halt_valid0", {31'b0, if_valid}, 32'h0);
        chk("halt_addr0", imem_addr, 32'h6);
        step();
        chk("halt_valid1", {31'b0, if_valid}, 32'h0);
        chk("halt_addr1", imem_addr, 32'h6);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        step();
        chk("resume_redir_addr", imem_addr, 32'h20);
        @(negedge clk);
        redirect_valid = 1'b0;
        step();
        chk("resume_valid", {31'b0, if_valid}, 32'h1);
        chk("resume_pc", if_pc, 32'h20);
        chk("resume_instr", if_instr, mem_word(32'h20));
        chk("resume_mis", {31'b0, mis0}, 32'h0);
        chk("resume_addr", imem_addr, 32'h24);
        @(negedge clk);
`else
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3A;
        step();
        chk("mask_redir_addr", imem_addr, 32'h38);
        chk("mask_redir_valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        step();
        chk("mask_pc", if_pc, 32'h38);
        chk("mask_instr", if_instr, mem_word(32'h38));
        @(negedge clk);
`endif

        // Fill the queue, then drop reset between edges.
        if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        @(negedge clk);
        redirect_valid = 1'b0;
        step();
        step();
        chk("full_valid", {31'b0, if_valid}, 32'h1);
        chk("full_addr", imem_addr, 32'h48);
        chk("full_pc", if_pc, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, if_valid}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_w_valid", {31'b0, w_valid}, 32'h0);
        chk("async_rst_w_addr", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;
        if_ready = 1'b1;
        step();
        chk("restart0_pc", if_pc, 32'h0);
        chk("restart0_instr", if_instr, 32'h11);
        chk("wrap0_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap0_instr", w_instr, mem_word(32'hFFFF_FFFC));
        chk("wrap0_addr", w_addr, 32'h0);
        step();
        chk("restart1_pc", if_pc, 32'h4);
        chk("restart1_instr", if_instr, 32'h22);
        chk("wrap1_pc", w_pc, 32'h0);
        chk("wrap1_instr", w_instr, 32'h11);
        step();
        chk("restart2_pc", if_pc, 32'h8);
        chk("restart2_instr", if_instr, 32'h33);
        step();
        chk("restart3_pc", if_pc, 32'hC);
        chk("restart3_instr", if_instr, 32'h44);
        chk("restart3_valid", {31'b0, if_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
